// File: rtl/uart_rx_param.sv
// 16x oversampled UART receiver: majority-voted samples, optional parity, 1-2 stop bits,
// error flags, and a held key_code output that auto-clears after a programmable idle time.
module uart_rx_param #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int HOLD_BITS = 800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [DATA_BITS-1:0] key_code,
    output logic                 busy
);
    localparam int DIV_RAW  = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_MAX = HOLD_BITS * 16;
    localparam int HW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
    } state_t;

    state_t               state, state_next;
    logic                 sync1, rs, rs_prev;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [3:0]           sub;
    logic [BW-1:0]        bit_cnt;
    logic                 samp_a, samp_b, maj, at_sample;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_flag, frm_flag, exp_par;
    logic                 start_go, done_go, good;
    logic [HW-1:0]        hold_cnt;

    assign tick      = (tick_cnt == DIV_LAST);
    assign at_sample = tick && (sub == 4'd9);
    assign maj       = (samp_a & samp_b) | (samp_a & rs) | (samp_b & rs);
    assign exp_par   = (PARITY == 2) ? ^shreg : ~^shreg;
    assign good      = ~par_flag & ~frm_flag & maj;
    assign rx_valid  = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
            state   <= S_IDLE;
        end else begin
            sync1   <= rxd;
            rs      <= sync1;
            rs_prev <= rs;
            state   <= state_next;
        end
    end

    // The final stop-bit vote moves straight to DONE, leaving the rest of the stop bit free for a new start.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        done_go    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rs_prev && !rs) begin
                    state_next = S_START;
                    start_go   = 1'b1;
                end
            end
            S_START: begin
                if (at_sample) state_next = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (at_sample && bit_cnt == DATA_LAST)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_sample) state_next = S_STOP;
            end
            S_STOP: begin
                if (at_sample && bit_cnt == STOP_LAST) begin
                    state_next = S_DONE;
                    done_go    = 1'b1;
                end
            end
            S_DONE:  state_next = frame_err ? S_BREAK : S_IDLE;
            S_BREAK: if (rs) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            sub      <= '0;
            bit_cnt  <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
        end else begin
            if (start_go || tick) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + 1'b1;

            if (start_go)  sub <= '0;
            else if (tick) sub <= sub + 4'd1;

            if (tick && sub == 4'd7) samp_a <= rs;
            if (tick && sub == 4'd8) samp_b <= rs;

            if (start_go) begin
                bit_cnt <= '0;
            end else if (at_sample) begin
                if (state == S_DATA)      bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                else if (state == S_STOP) bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else if (start_go) begin
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else if (at_sample) begin
            if (state == S_DATA)             shreg    <= {maj, shreg[DATA_BITS-1:1]};
            if (state == S_PARITY)           par_flag <= (maj != exp_par);
            if (state == S_STOP && !maj)     frm_flag <= 1'b1;
        end
    end

    // Frame results are registered on the edge entering DONE so they are valid alongside rx_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (done_go) begin
            rx_data    <= shreg;
            parity_err <= par_flag;
            frame_err  <= frm_flag | ~maj;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            key_code <= '0;
        end else if (done_go && good) begin
            hold_cnt <= '0;
            key_code <= shreg;
        end else if (HOLD_MAX != 0 && tick && hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LIM - 1'b1) key_code <= '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance with a 4-bit hold and an 8E1 instance
// with no hold, driven by directed and random frames and checked by per-instance monitors.
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_n = 1'b1, rxd_e = 1'b1;
    logic [7:0] data_n, key_n, data_e, key_e;
    logic       vld_n, perr_n, ferr_n, busy_n;
    logic       vld_e, perr_e, ferr_e, busy_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         due;
    } exp_t;

    exp_t q_n[$];
    exp_t q_e[$];

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .HOLD_BITS(4)) u_dut_n (
        .clk(clk), .rst(rst), .rxd(rxd_n), .rx_data(data_n), .rx_valid(vld_n),
        .parity_err(perr_n), .frame_err(ferr_n), .key_code(key_n), .busy(busy_n));

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .HOLD_BITS(0)) u_dut_e (
        .clk(clk), .rst(rst), .rxd(rxd_e), .rx_data(data_e), .rx_valid(vld_e),
        .parity_err(perr_e), .frame_err(ferr_e), .key_code(key_e), .busy(busy_e));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic setLine(input bit to_e, input logic v);
        if (to_e) rxd_e = v;
        else      rxd_n = v;
    endtask

    task automatic driveBit(input bit to_e, input logic v);
        setLine(to_e, v);
        repeat (16) @(negedge clk);
    endtask

    // One bit is 16 clocks here; the receiver sees the start edge 3 clocks late (sync + edge detect)
    // and reports on the edge after the mid-bit vote of the last stop bit.
    task automatic applyStimulus(input bit to_e, input logic [7:0] data,
                                 input bit bad_par, input bit bad_stop);
        exp_t e;
        int   nbits;
        nbits  = to_e ? 11 : 10;
        e.data = data;
        e.perr = to_e && bad_par;
        e.ferr = bad_stop;
        e.due  = cyc + 16 * (nbits - 1) + 13;
        if (to_e) q_e.push_back(e);
        else      q_n.push_back(e);
        driveBit(to_e, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(to_e, data[i]);
        if (to_e) driveBit(to_e, (^data) ^ bad_par);
        driveBit(to_e, !bad_stop);
    endtask

    exp_t       got_n;
    logic [7:0] km_n = '0, km_prev_n = '0, key_prev_n = '0;
    int         last_n = 0;
    bit         live_n = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            km_n   = '0;
            live_n = 1'b0;
        end else begin
            if (vld_n) begin
                if (q_n.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL n_unexpected_valid actual=1 expected=0 data=%0h", data_n);
                end else begin
                    got_n = q_n.pop_front();
                    checkOutput("n_data", data_n, got_n.data);
                    checkOutput("n_parity_err", perr_n, got_n.perr);
                    checkOutput("n_frame_err", ferr_n, got_n.ferr);
                    checkOutput("n_latency", cyc, got_n.due);
                    if (!got_n.perr && !got_n.ferr) begin
                        km_n   = got_n.data;
                        last_n = got_n.due;
                        live_n = 1'b1;
                    end
                end
            end
            if (live_n && (cyc - last_n) >= 64) begin
                km_n   = '0;
                live_n = 1'b0;
            end
            if (key_n !== key_prev_n || km_n !== km_prev_n) checkOutput("n_key", key_n, km_n);
        end
        key_prev_n = key_n;
        km_prev_n  = km_n;
    end

    exp_t       got_e;
    logic [7:0] km_e = '0, km_prev_e = '0, key_prev_e = '0;

    always @(negedge clk) begin
        if (rst) begin
            km_e = '0;
        end else begin
            if (vld_e) begin
                if (q_e.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL e_unexpected_valid actual=1 expected=0 data=%0h", data_e);
                end else begin
                    got_e = q_e.pop_front();
                    checkOutput("e_data", data_e, got_e.data);
                    checkOutput("e_parity_err", perr_e, got_e.perr);
                    checkOutput("e_frame_err", ferr_e, got_e.ferr);
                    checkOutput("e_latency", cyc, got_e.due);
                    if (!got_e.perr && !got_e.ferr) km_e = got_e.data;
                end
            end
            if (key_e !== key_prev_e || km_e !== km_prev_e) checkOutput("e_key", key_e, km_e);
        end
        key_prev_e = key_e;
        km_prev_e  = km_e;
    end

    initial begin
        int         d;
        logic [7:0] rd;
        bit         te, bp, bs;
        int         gap;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rst_valid_n", vld_n, 0);
        checkOutput("rst_data_n", data_n, 0);
        checkOutput("rst_perr_n", perr_n, 0);
        checkOutput("rst_ferr_n", ferr_n, 0);
        checkOutput("rst_key_n", key_n, 0);
        checkOutput("rst_busy_n", busy_n, 0);
        checkOutput("rst_valid_e", vld_e, 0);
        checkOutput("rst_data_e", data_e, 0);
        checkOutput("rst_perr_e", perr_e, 0);
        checkOutput("rst_ferr_e", ferr_e, 0);
        checkOutput("rst_key_e", key_e, 0);
        checkOutput("rst_busy_e", busy_e, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Clean 8N1 frame
        applyStimulus(1'b0, 8'h41, 1'b0, 1'b0);
        checkOutput("t1_busy_idle", busy_n, 0);
        checkOutput("t1_key", key_n, 8'h41);
        repeat (100) @(negedge clk);

        // Short low glitch must not start a frame
        rxd_n = 1'b0;
        repeat (5) @(negedge clk);
        rxd_n = 1'b1;
        checkOutput("t2_glitch_busy", busy_n, 1);
        repeat (30) @(negedge clk);
        checkOutput("t2_back_idle", busy_n, 0);
        checkOutput("t2_data_kept", data_n, 8'h41);

        // Even parity: good frame, then a wrong parity bit
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0);
        checkOutput("t3_parity_err", perr_e, 1);
        checkOutput("t3_key_kept", key_e, 8'h5A);
        repeat (20) @(negedge clk);

        // Low stop bit followed by a long break
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("t4_break_busy", busy_n, 1);
        checkOutput("t4_frame_err", ferr_n, 1);
        repeat (20) @(negedge clk);
        rxd_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t4_break_left", busy_n, 0);
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0);
        checkOutput("t4_clean_data", data_n, 8'h55);
        checkOutput("t4_clean_ferr", ferr_n, 0);
        repeat (20) @(negedge clk);

        // Hold timer expiry
        d = cyc + 157;
        applyStimulus(1'b0, 8'h20, 1'b0, 1'b0);
        while (cyc < d + 63) @(negedge clk);
        checkOutput("t5_key_held", key_n, 8'h20);
        @(negedge clk);
        checkOutput("t5_key_cleared", key_n, 8'h00);
        checkOutput("t5_data_kept", data_n, 8'h20);
        repeat (20) @(negedge clk);

        // Reset in the middle of bit 4
        rd = 8'h7E;
        driveBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0, rd[i]);
        rxd_n = rd[4];
        repeat (8) @(negedge clk);
        checkOutput("t6_busy_before", busy_n, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_data", data_n, 0);
        checkOutput("t6_rst_key", key_n, 0);
        checkOutput("t6_rst_busy", busy_n, 0);
        checkOutput("t6_rst_valid", vld_n, 0);
        checkOutput("t6_rst_ferr", ferr_n, 0);
        @(negedge clk);
        rxd_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 8'h7E, 1'b0, 1'b0);
        checkOutput("t6_next_frame", data_n, 8'h7E);
        repeat (20) @(negedge clk);

        // Random frames on both receivers, including back-to-back and broken frames
        for (int i = 0; i < 24; i++) begin
            te = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            bp = te && ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 5) == 0);
            applyStimulus(te, rd, bp, bs);
            if (bs) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                setLine(te, 1'b1);
                repeat (16) @(negedge clk);
            end
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 90));
            repeat (gap) @(negedge clk);
        end

        for (int k = 0; k < 400 && (q_n.size() != 0 || q_e.size() != 0); k++) @(negedge clk);
        checkOutput("drain_pending", q_n.size() + q_e.size(), 0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
